// File: rtl/frame_tx_arbiter.sv
// ---------------------------------------------------------------------------
// frame_tx_arbiter
//
// Round-robin arbiter that shares one serial frame transmitter between N
// requesters. A winner is picked from the requesters that are asking, the
// transmitter is started, and the winner's words are steered onto txData. The
// arbiter then waits for txDone, with a watchdog. After the frame it holds an
// idle gap so the receiver's start-delimiter search can resynchronise.
//
// Ports
//   clock      in   system clock, all logic on posedge
//   resetN     in   asynchronous active-low reset
//   req        in   [N]        per-requester request level
//   reqData    in   [N*WIDTH]  requester k's word on [k*WIDTH +: WIDTH]
//   grant      out  [N]        one-hot owner of the transmitter, 0 when none
//   wordIndex  out  [LOGSIZE]  word index wanted by the transmitter (= txIndex)
//   done       out  [N]        one-cycle pulse: owner's frame completed
//   error      out  [N]        one-cycle pulse: owner's frame hit the watchdog
//   busy       out             high in every state except IDLE
//   txStart    out             one-cycle start pulse to the transmitter
//   txIndex    in   [LOGSIZE]  word index from the transmitter
//   txData     out  [WIDTH]    word driven to the transmitter
//   txDone     in              pulse after the last bit of the last word
// ---------------------------------------------------------------------------
module frame_tx_arbiter #(
    parameter int N          = 4,
    parameter int WIDTH      = 16,
    parameter int LOGSIZE    = 1,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   reqData,
    output logic [N-1:0]         grant,
    output logic [LOGSIZE-1:0]   wordIndex,
    output logic [N-1:0]         done,
    output logic [N-1:0]         error,
    output logic                 busy,
    output logic                 txStart,
    input  logic [LOGSIZE-1:0]   txIndex,
    output logic [WIDTH-1:0]     txData,
    input  logic                 txDone
);

    localparam int LAST_W = $clog2(N);
    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam int GAP_W  = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [TMR_W-1:0]  TMR_INIT  = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_CYCLES);
    localparam logic [LAST_W-1:0] LAST_INIT = LAST_W'(N - 1);
    localparam logic [N-1:0]      ONE_HOT0  = N'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]        state;
    logic [LAST_W-1:0] last;       // most recent owner; scan starts just above it
    logic [LAST_W-1:0] owner;      // index form of grant while in SEND
    logic [TMR_W-1:0]  timer;
    logic [GAP_W-1:0]  gap_count;

    logic              found;
    logic [LAST_W-1:0] next_win;

    // Round-robin pick: first set req bit scanning upward from last+1, wrapping.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        found    = 1'b0;
        next_win = '0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(last) + 1 + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                next_win = LAST_W'(idx);
            end
        end
    end

    // grant is one-hot or zero, so an AND-OR mux selects the owner's word and
    // yields zero when nobody owns the transmitter.
    always_comb begin
        txData = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                txData = txData | reqData[k*WIDTH +: WIDTH];
            end
        end
    end

    assign wordIndex = txIndex;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= ST_IDLE;
            grant     <= '0;
            done      <= '0;
            error     <= '0;
            txStart   <= 1'b0;
            busy      <= 1'b0;
            last      <= LAST_INIT;   // requester 0 has top priority after reset
            owner     <= '0;
            timer     <= '0;
            gap_count <= '0;
        end else begin
            // Pulse outputs default low; the cases below raise them for one cycle.
            txStart <= 1'b0;
            done    <= '0;
            error   <= '0;

            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant   <= ONE_HOT0 << next_win;
                        owner   <= next_win;
                        txStart <= 1'b1;
                        timer   <= TMR_INIT;
                        busy    <= 1'b1;
                        state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    // txDone has priority over a simultaneous watchdog expiry.
                    if (txDone) begin
                        done      <= grant;
                        grant     <= '0;
                        last      <= owner;
                        gap_count <= GAP_INIT;
                        state     <= ST_GAP;
                    end else if (timer == '0) begin
                        error     <= grant;
                        grant     <= '0;
                        last      <= owner;
                        gap_count <= GAP_INIT;
                        state     <= ST_GAP;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                ST_GAP: begin
                    // Holds GAP_CYCLES+1 cycles; busy drops together with the
                    // return to IDLE.
                    if (gap_count == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_count <= gap_count - GAP_W'(1);
                    end
                end

                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_tx_arbiter.md
# frame_tx_arbiter

Round-robin arbiter that shares one serial frame transmitter between N requesters. Each requester presents a packet of 2^LOGSIZE words of WIDTH bits. The arbiter picks a winner, starts the transmitter, and steers the winner's words onto the transmitter data bus. It then waits for frame completion, with a watchdog, and enforces an idle gap between frames so the receiver's start-delimiter search resynchronises. It sits between client logic and the frame transmitter on the TX side of the link.

## Interface
- N, 4: number of requesters (≥2).
- WIDTH, 16: word width, equal to the transmitter word width.
- LOGSIZE, 1: log2 of words per packet.
- GAP_CYCLES, 16: idle cycles enforced after each frame (0 allowed).
- TIMEOUT, 4096: maximum cycles to wait for txDone after txStart (≥2).

Ports:
- clock  in  1  single system clock, all logic on posedge.
- resetN  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level; bit k belongs to requester k.
- reqData  in  N*WIDTH  requester k's current word on bits [k*WIDTH +: WIDTH].
- grant  out  N  one-hot owner of the transmitter; all zero when none.
- wordIndex  out  LOGSIZE  word index the transmitter currently wants; equal to txIndex, broadcast to all requesters.
- done  out  N  one-cycle pulse on bit k when requester k's frame has completed.
- error  out  N  one-cycle pulse on bit k when requester k's frame is aborted by the watchdog.
- busy  out  1  high in every state except IDLE.
- txStart  out  1  one-cycle start pulse to the transmitter.
- txIndex  in  LOGSIZE  word index from the transmitter.
- txData  out  WIDTH  word driven to the transmitter.
- txDone  in  1  one-cycle pulse from the transmitter after the last bit of the last word.

## Operation
- States and behaviour:
  - IDLE: if req ≠ 0, the winner is the first set bit scanning upward from (last+1) mod N with wrap-around. On the next edge: grant ← onehot(winner), txStart ← 1, timer ← TIMEOUT-1, state ← SEND. If req = 0, stay in IDLE.
  - SEND: grant is held constant.
    - txData = reqData slice selected by grant, combinational.
    - Requesters must drive the word for wordIndex combinationally.
    - txDone=1: done[winner] ← 1, grant ← 0, last ← winner, state ← GAP, gapCount ← GAP_CYCLES.
    - Otherwise, timer = 0: error[winner] ← 1, grant ← 0, last ← winner, state ← GAP, gapCount ← GAP_CYCLES.
    - Otherwise, timer decrements.
  - GAP: gapCount = 0 → IDLE; otherwise gapCount decrements. GAP therefore lasts GAP_CYCLES+1 cycles. req is ignored here.
- Frames are never pre-empted. Dropping req during SEND has no effect, and done/error still pulse.
- A requester that keeps req high after done is re-eligible. The pointer gives all other requesters priority first.
- txDone and timer expiry in the same cycle: txDone wins, so done pulses and error does not.
- txDone seen in IDLE or GAP is ignored, with no pulse.
- txData = 0 when grant = 0.
- Widths:
  - timer: clog2(TIMEOUT) bits.
  - gapCount: clog2(GAP_CYCLES+1) bits, minimum 1.
  - last: clog2(N) bits.
  - All counters are unsigned with no wrap.

## Timing
- Reset (async assert, sync release):
  - State ← IDLE.
  - Outputs grant, done, error, txStart and busy ← 0.
  - last ← N-1, so requester 0 has top priority after reset.
  - Reset mid-SEND abandons the frame with no done or error pulse.
- Request-to-start latency: req seen in IDLE in cycle c → grant, txStart and busy high in cycle c+1. txStart is high exactly one cycle.
- done and error assert in the cycle after txDone or expiry, last one cycle, and coincide with grant falling to 0.
- Frame-to-frame: txDone in cycle c → next txStart no earlier than cycle c+GAP_CYCLES+3.
- Watchdog: SEND lasts at most TIMEOUT cycles. error asserts TIMEOUT cycles after the txStart cycle.
- All outputs are registered except txData and wordIndex.

## Test plan
- Single requester: req=0010, reqData word1=16'hBEEF. Required response:
  - grant=0010 and a one-cycle txStart one cycle later.
  - With txIndex=1, txData=16'hBEEF.
  - txDone pulse → done=0010 for one cycle, grant=0000.
- Fairness: req=1111 held, with txDone 40 cycles after each txStart. Grants must run 0001, 0010, 0100, 1000, 0001, with no repeats while others wait.
- Gap: GAP_CYCLES=16, req held, txDone in cycle c → next txStart exactly in cycle c+19. busy stays high throughout GAP.
- Watchdog: TIMEOUT=64, txDone never arrives → error=grant for one cycle, 64 cycles after txStart. Then GAP, then the next requester is granted. A separate case with txDone and expiry in the same cycle must give done only.
- Reset mid-SEND: resetN low → grant, txStart, done and busy drop to 0 immediately. After release with req=0101, requester 0 is granted first.
- Request withdrawal: req drops to 0 two cycles after grant → frame completes, done pulses on txDone, and the arbiter returns to IDLE after the gap with no new grant.
